// File: rtl/core_pkg.sv
// core_pkg: shared types and sizing for the vector dispatcher
package core_pkg;
  localparam int InsnIDNum = 8;
  localparam int IdW = $clog2(InsnIDNum);
  typedef logic [IdW-1:0] insn_id_t;
  typedef logic [IdW:0] insn_ptr_t;
  typedef struct packed {
    logic [7:0]  vtype;
    logic [15:0] vl;
  } vec_context_t;
  typedef struct packed {
    logic valid;
    logic cmt;
    logic done;
    logic illegal;
  } disp_entry_t;
  typedef enum logic {IDLE, WAIT} issue_state_e;
endpackage

// File: rtl/rvv_id_table.sv
// rvv_id_table: per-ID entry table with tail/commit/head pointers and in-order retire selection
module rvv_id_table import core_pkg::*; (
  input  logic     clk,
  input  logic     rst,
  input  logic     alloc,
  input  logic     nonspec,
  input  logic     flush,
  input  logic     done,
  input  insn_id_t done_id,
  input  logic     done_illegal,
  output logic     full,
  output insn_id_t tail_id,
  output logic     commit,
  output insn_id_t commit_id,
  output logic     retire,
  output insn_id_t retire_id,
  output logic     retire_illegal
);
  disp_entry_t ent [InsnIDNum];
  disp_entry_t ent_nxt [InsnIDNum];
  insn_ptr_t tail, cpt, head, cpt_nxt, tail_nxt, span;
  disp_entry_t hd;
  assign tail_id = tail[IdW-1:0];
  assign commit_id = cpt[IdW-1:0];
  assign retire_id = head[IdW-1:0];
  assign hd = ent[head[IdW-1:0]];
  assign full = (tail ^ head) == insn_ptr_t'(InsnIDNum);
  assign commit = nonspec && cpt != tail && ent[cpt[IdW-1:0]].valid;
  assign retire = hd.valid && hd.done && (hd.cmt || hd.illegal);
  assign retire_illegal = hd.illegal;
  assign cpt_nxt = cpt + insn_ptr_t'(commit);
  assign tail_nxt = flush ? cpt_nxt : tail + insn_ptr_t'(alloc);
  assign span = tail - cpt_nxt;
  // entry updates: allocate, grant, done, then clears (retire/flush) take priority
  always_comb begin
    for (int i = 0; i < InsnIDNum; i++) begin
      ent_nxt[i] = ent[i];
      if (alloc && tail_id == insn_id_t'(i)) ent_nxt[i] = '{valid: 1'b1, default: 1'b0};
      if (commit && commit_id == insn_id_t'(i)) ent_nxt[i].cmt = 1'b1;
      if (done && done_id == insn_id_t'(i) && ent[i].valid) begin
        ent_nxt[i].done = 1'b1;
        ent_nxt[i].illegal = done_illegal;
      end
      if ((retire && retire_id == insn_id_t'(i)) ||
          (flush && {1'b0, insn_id_t'(insn_id_t'(i) - cpt_nxt[IdW-1:0])} < span))
        ent_nxt[i] = '0;
    end
  end
  // table and pointer state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < InsnIDNum; i++) ent[i] <= '0;
      tail <= '0;
      cpt <= '0;
      head <= '0;
    end else begin
      for (int i = 0; i < InsnIDNum; i++) ent[i] <= ent_nxt[i];
      tail <= tail_nxt;
      cpt <= cpt_nxt;
      head <= head + insn_ptr_t'(retire);
    end
  end
  a_nonspec_live: assert property (@(posedge clk) disable iff (rst) nonspec |-> cpt != tail);
endmodule

// File: rtl/rvv_dispatcher.sv
// rvv_dispatcher: scalar-side issue/commit/done/retire initiator for the vector coprocessor
module rvv_dispatcher import core_pkg::*; (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         req_valid_i,
  output logic         req_ready_o,
  input  logic [31:0]  req_insn_i,
  input  vec_context_t req_vec_context_i,
  input  logic         nonspec_i,
  input  logic         flush_i,
  output logic         vec_valid_o,
  input  logic         vec_ready_i,
  output logic [31:0]  vec_insn_o,
  output insn_id_t     vec_insn_id_o,
  output vec_context_t vec_context_o,
  output logic         vec_flush_o,
  output logic         vec_can_commit_o,
  output insn_id_t     vec_can_commit_id_o,
  input  logic         vec_done_i,
  input  insn_id_t     vec_done_id_i,
  input  logic         vec_illegal_i,
  output logic         retire_valid_o,
  output insn_id_t     retire_id_o,
  output logic         retire_illegal_o
);
  issue_state_e state, state_nxt;
  logic full, alloc, commit, retire, retire_ill;
  insn_id_t tail_id, commit_id, retire_id;
  assign alloc = req_valid_i && req_ready_o;
  rvv_id_table u_table (
    .clk(clk_i), .rst(rst_i), .alloc(alloc), .nonspec(nonspec_i), .flush(flush_i),
    .done(vec_done_i), .done_id(vec_done_id_i), .done_illegal(vec_illegal_i),
    .full(full), .tail_id(tail_id), .commit(commit), .commit_id(commit_id),
    .retire(retire), .retire_id(retire_id), .retire_illegal(retire_ill)
  );
  // issue FSM state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else state <= state_nxt;
  end
  // issue FSM next state: a flush abandons a pending issue
  always_comb begin
    state_nxt = state == IDLE ? (alloc ? WAIT : IDLE) : (flush_i || vec_ready_i ? IDLE : WAIT);
  end
  // issue FSM outputs
  always_comb begin
    req_ready_o = state == IDLE && !full && !flush_i && !rst_i;
    vec_valid_o = state == WAIT;
  end
  // issue payload held stable while waiting for the coprocessor
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vec_insn_o <= '0;
      vec_context_o <= '0;
      vec_insn_id_o <= '0;
    end else if (alloc) begin
      vec_insn_o <= req_insn_i;
      vec_context_o <= req_vec_context_i;
      vec_insn_id_o <= tail_id;
    end
  end
  // single-cycle flush, commit-permission and retire pulses
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vec_flush_o <= 1'b0;
      vec_can_commit_o <= 1'b0;
      vec_can_commit_id_o <= '0;
      retire_valid_o <= 1'b0;
      retire_id_o <= '0;
      retire_illegal_o <= 1'b0;
    end else begin
      vec_flush_o <= flush_i;
      vec_can_commit_o <= commit;
      vec_can_commit_id_o <= commit ? commit_id : '0;
      retire_valid_o <= retire;
      retire_id_o <= retire ? retire_id : '0;
      retire_illegal_o <= retire && retire_ill;
    end
  end
endmodule

// File: tb/tb_rvv_dispatcher.sv
// tb_rvv_dispatcher: directed self-checking bench for rvv_dispatcher
module tb_rvv_dispatcher;
  import core_pkg::*;
  logic clk = 0, rst = 1;
  logic req_valid = 0, req_ready, nonspec = 0, flush = 0;
  logic [31:0] req_insn = 0, vec_insn;
  vec_context_t req_ctx = '0, vec_ctx;
  logic vec_valid, vec_ready = 0, vec_flush, can_commit, vec_done = 0, vec_illegal = 0;
  logic retire_valid, retire_illegal;
  insn_id_t vec_id, can_commit_id, done_id = 0, retire_id;
  int total = 0, bad = 0;
  logic [IdW:0] cc_q[$], ret_q[$];
  rvv_dispatcher dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_insn_i(req_insn), .req_vec_context_i(req_ctx), .nonspec_i(nonspec), .flush_i(flush),
    .vec_valid_o(vec_valid), .vec_ready_i(vec_ready), .vec_insn_o(vec_insn),
    .vec_insn_id_o(vec_id), .vec_context_o(vec_ctx), .vec_flush_o(vec_flush),
    .vec_can_commit_o(can_commit), .vec_can_commit_id_o(can_commit_id),
    .vec_done_i(vec_done), .vec_done_id_i(done_id), .vec_illegal_i(vec_illegal),
    .retire_valid_o(retire_valid), .retire_id_o(retire_id), .retire_illegal_o(retire_illegal)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (can_commit) cc_q.push_back({1'b0, can_commit_id});
    if (retire_valid) ret_q.push_back({retire_illegal, retire_id});
  end
  initial begin
    #500000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
  task automatic step();
    @(negedge clk);
  endtask
  task automatic do_reset();
    {req_valid, nonspec, flush, vec_ready, vec_done, vec_illegal} = '0;
    rst = 1;
    repeat (2) step();
    rst = 0;
    cc_q.delete();
    ret_q.delete();
  endtask
  task automatic issue(input logic [31:0] insn, output insn_id_t id, output logic ok,
                       output logic [31:0] wi, output vec_context_t wc);
    req_valid = 1;
    req_insn = insn;
    req_ctx = '{vtype: insn[7:0], vl: insn[31:16]};
    for (int i = 0; i < 20; i++) begin
      #1;
      if (req_ready) break;
      step();
    end
    step();
    req_valid = 0;
    ok = vec_valid;
    id = vec_id;
    wi = vec_insn;
    wc = vec_ctx;
    vec_ready = 1;
    step();
    vec_ready = 0;
  endtask
  task automatic pulse_nonspec(input int n);
    nonspec = 1;
    repeat (n) step();
    nonspec = 0;
  endtask
  task automatic send_done(input insn_id_t id, input logic ill);
    vec_done = 1;
    done_id = id;
    vec_illegal = ill;
    step();
    vec_done = 0;
    vec_illegal = 0;
  endtask
  task automatic test_reset();
    rst = 1;
    step();
    #1;
    total++;
    if ({req_ready, vec_valid, vec_flush, can_commit, retire_valid, vec_id, vec_insn} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got=%b/%b/%b/%b/%b id=%0h insn=%0h exp=all zero",
               req_ready, vec_valid, vec_flush, can_commit, retire_valid, vec_id, vec_insn);
    end
    rst = 0;
    #1;
    total++;
    if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
    step();
  endtask
  task automatic test_in_order();
    insn_id_t id; logic ok; logic [31:0] wi; vec_context_t wc;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      issue(32'h00A5_1000 + k, id, ok, wi, wc);
      total++;
      if ({ok, id, wi} !== {1'b1, insn_id_t'(k), 32'h00A5_1000 + k}) begin
        bad++; $display("FAIL inorder_issue%0d got=%b/%0h/%0h exp=1/%0h/%0h", k, ok, id, wi, k, 32'h00A5_1000 + k);
      end
    end
    total++;
    if (wc !== '{vtype: 8'h02, vl: 16'h00A5}) begin bad++; $display("FAIL inorder_ctx got=%0h exp=%0h", wc, 24'h02_00A5); end
    pulse_nonspec(3);
    repeat (2) step();
    total++;
    if (cc_q.size() != 3 || cc_q[0] !== 0 || cc_q[1] !== 1 || cc_q[2] !== 2) begin
      bad++; $display("FAIL inorder_commit got=%p exp=0,1,2", cc_q);
    end
    send_done(2, 0);
    send_done(0, 0);
    send_done(1, 0);
    repeat (4) step();
    total++;
    if (ret_q.size() != 3 || ret_q[0] !== 0 || ret_q[1] !== 1 || ret_q[2] !== 2) begin
      bad++; $display("FAIL inorder_retire got=%p exp=0,1,2", ret_q);
    end
  endtask
  task automatic test_full_wrap();
    insn_id_t id; logic ok; logic [31:0] wi; vec_context_t wc;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      issue(32'h2000 + k, id, ok, wi, wc);
      total++;
      if ({ok, id} !== {1'b1, insn_id_t'(k)}) begin bad++; $display("FAIL full_issue%0d got=%b/%0h exp=1/%0h", k, ok, id, k); end
    end
    #1;
    total++;
    if (req_ready !== 1'b0) begin bad++; $display("FAIL full_ready got=%b exp=0", req_ready); end
    pulse_nonspec(1);
    send_done(0, 0);
    repeat (3) step();
    total++;
    if (ret_q.size() != 1 || ret_q[0] !== 0 || cc_q.size() != 1 || cc_q[0] !== 0) begin
      bad++; $display("FAIL full_retire0 got=%p/%p exp=0/0", ret_q, cc_q);
    end
    #1;
    total++;
    if (req_ready !== 1'b1) begin bad++; $display("FAIL full_ready_after got=%b exp=1", req_ready); end
    issue(32'h2008, id, ok, wi, wc);
    total++;
    if ({ok, id} !== {1'b1, insn_id_t'(0)}) begin bad++; $display("FAIL wrap_id got=%b/%0h exp=1/0", ok, id); end
  endtask
  task automatic test_flush();
    insn_id_t id; logic ok; logic [31:0] wi; vec_context_t wc;
    do_reset();
    for (int k = 0; k < 4; k++) issue(32'h3000 + k, id, ok, wi, wc);
    pulse_nonspec(2);
    flush = 1;
    #1;
    total++;
    if (req_ready !== 1'b0) begin bad++; $display("FAIL flush_blocks_ready got=%b exp=0", req_ready); end
    step();
    flush = 0;
    total++;
    if ({vec_flush, vec_valid} !== 2'b10) begin bad++; $display("FAIL flush_pulse got=%b%b exp=10", vec_flush, vec_valid); end
    step();
    total++;
    if (vec_flush !== 1'b0) begin bad++; $display("FAIL flush_pulse_end got=%b exp=0", vec_flush); end
    send_done(3, 0);
    issue(32'h3010, id, ok, wi, wc);
    total++;
    if ({ok, id} !== {1'b1, insn_id_t'(2)}) begin bad++; $display("FAIL flush_reuse2 got=%b/%0h exp=1/2", ok, id); end
    issue(32'h3011, id, ok, wi, wc);
    total++;
    if ({ok, id} !== {1'b1, insn_id_t'(3)}) begin bad++; $display("FAIL flush_reuse3 got=%b/%0h exp=1/3", ok, id); end
    pulse_nonspec(2);
    send_done(0, 0);
    send_done(1, 0);
    send_done(2, 0);
    repeat (5) step();
    total++;
    if (cc_q.size() != 4 || cc_q[2] !== 2 || cc_q[3] !== 3) begin bad++; $display("FAIL flush_commit got=%p exp=0,1,2,3", cc_q); end
    total++;
    if (ret_q.size() != 3 || ret_q[0] !== 0 || ret_q[1] !== 1 || ret_q[2] !== 2) begin
      bad++; $display("FAIL flush_retire got=%p exp=0,1,2 (stale done on 3 dropped)", ret_q);
    end
  endtask
  task automatic test_illegal();
    insn_id_t id; logic ok; logic [31:0] wi; vec_context_t wc;
    do_reset();
    issue(32'h4000, id, ok, wi, wc);
    send_done(0, 1);
    repeat (3) step();
    total++;
    if (ret_q.size() != 1 || ret_q[0] !== {1'b1, insn_id_t'(0)} || cc_q.size() != 0) begin
      bad++; $display("FAIL illegal_retire got=%p cc=%p exp=illegal id0, no commit", ret_q, cc_q);
    end
  endtask
  task automatic test_flush_wait();
    insn_id_t id; logic ok; logic [31:0] wi; vec_context_t wc;
    do_reset();
    req_valid = 1;
    req_insn = 32'h5000;
    step();
    req_valid = 0;
    total++;
    if ({vec_valid, vec_id} !== {1'b1, insn_id_t'(0)}) begin bad++; $display("FAIL fwait_pending got=%b/%0h exp=1/0", vec_valid, vec_id); end
    flush = 1;
    step();
    flush = 0;
    total++;
    if ({vec_valid, vec_flush} !== 2'b01) begin bad++; $display("FAIL fwait_drop got=%b%b exp=01", vec_valid, vec_flush); end
    step();
    issue(32'h5001, id, ok, wi, wc);
    total++;
    if ({ok, id, wi} !== {1'b1, insn_id_t'(0), 32'h5001}) begin bad++; $display("FAIL fwait_reuse got=%b/%0h/%0h exp=1/0/5001", ok, id, wi); end
  endtask
  task automatic test_reset_wait();
    insn_id_t id; logic ok; logic [31:0] wi; vec_context_t wc;
    do_reset();
    for (int k = 0; k < 3; k++) issue(32'h6000 + k, id, ok, wi, wc);
    req_valid = 1;
    req_insn = 32'h6003;
    step();
    req_valid = 0;
    total++;
    if ({vec_valid, vec_id} !== {1'b1, insn_id_t'(3)}) begin bad++; $display("FAIL rwait_pending got=%b/%0h exp=1/3", vec_valid, vec_id); end
    #2;
    rst = 1;
    #1;
    total++;
    if ({vec_valid, vec_id, vec_insn, vec_ctx, req_ready, vec_flush, can_commit, retire_valid} !== '0) begin
      bad++; $display("FAIL rwait_async got=%b/%0h/%0h/%0h/%b exp=all zero", vec_valid, vec_id, vec_insn, vec_ctx, req_ready);
    end
    step();
    rst = 0;
    issue(32'h6100, id, ok, wi, wc);
    total++;
    if ({ok, id} !== {1'b1, insn_id_t'(0)}) begin bad++; $display("FAIL rwait_first_id got=%b/%0h exp=1/0", ok, id); end
  endtask
  initial begin
    test_reset();
    test_in_order();
    test_full_wrap();
    test_flush();
    test_illegal();
    test_flush_wait();
    test_reset_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
